// File: rtl/set_job_dispatcher.sv
// set_job_dispatcher: host job queue and single-issue front-end for the SET candidate-counting engine.
// Build option: define SJD_TIMEOUT_EN to build the RUN watchdog (TIMEOUT_CYC cycles, result 8'hFF with res_err=1).

// sjd_fifo: generic synchronous FIFO, storage plus occupancy count, head visible combinationally.
// Latency: a pushed word is at the head one cycle after the push edge when the FIFO was empty.
// Backpressure: full is raised at DEPTH entries; pushes while full and pops while empty are dropped.
module sjd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CNT_FULL);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && (count != '0);
  assign head_dat = mem[rd_ptr];

  // Storage, pointers (wrapping modulo DEPTH) and occupancy; push and pop in one cycle leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// set_job_dispatcher: queues host jobs, issues one at a time to SET, returns tagged candidate counts.
// Latency: job pushed at edge N into an empty idle queue gives set_en in the cycle after edge N+1.
// Backpressure: job_ready low while the queue is full; a pending result blocks further issue until res_ready.
module set_job_dispatcher #(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 80
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [23:0]              job_central,
  input  logic [11:0]              job_radius,
  input  logic [1:0]               job_mode,
  input  logic [TAG_W-1:0]         job_tag,
  output logic                     set_en,
  output logic [23:0]              set_central,
  output logic [11:0]              set_radius,
  output logic [1:0]               set_mode,
  input  logic                     set_busy,
  input  logic                     set_valid,
  input  logic [7:0]               set_candidate,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_candidate,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   q_count
);

  typedef struct packed {
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } job_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  job_t             push_job;
  job_t             head_job;
  logic             q_full;
  logic             pop;
  logic             cap_ok;
  logic             cap_to;
  logic             res_clr;
  logic             timeout_hit;
  logic [TAG_W-1:0] tag_r;

  assign push_job  = {job_central, job_radius, job_mode, job_tag};
  assign job_ready = !q_full;

  sjd_fifo #(
    .W     ($bits(job_t)),
    .DEPTH (DEPTH)
  ) u_job_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (job_valid),
    .push_dat (push_job),
    .pop      (pop),
    .head_dat (head_job),
    .count    (q_count),
    .full     (q_full)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the one-cycle strobes: pop, start pulse, result capture and result release.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    set_en    = 1'b0;
    cap_ok    = 1'b0;
    cap_to    = 1'b0;
    res_clr   = 1'b0;
    case (state)
      IDLE: begin
        if ((q_count != '0) && !set_busy && !res_valid) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        set_en    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        // A real result in the same cycle as the watchdog expiry takes priority.
        if (set_valid) begin
          cap_ok    = 1'b1;
          state_nxt = HOLD;
        end else if (timeout_hit) begin
          cap_to    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SET operands and the job tag load only when a job leaves the queue, so they stay stable until the next issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_central <= '0;
      set_radius  <= '0;
      set_mode    <= '0;
      tag_r       <= '0;
    end else if (pop) begin
      set_central <= head_job.central;
      set_radius  <= head_job.radius;
      set_mode    <= head_job.mode;
      tag_r       <= head_job.tag;
    end
  end

  // Result register: captured on set_valid (or watchdog) in RUN, held through HOLD, released on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
    end else if (cap_ok) begin
      res_valid     <= 1'b1;
      res_candidate <= set_candidate;
      res_tag       <= tag_r;
    end else if (cap_to) begin
      res_valid     <= 1'b1;
      res_candidate <= 8'hFF;
      res_tag       <= tag_r;
    end else if (res_clr) begin
      res_valid     <= 1'b0;
    end
  end

`ifdef SJD_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYC - 1);
  localparam logic [TCW-1:0] TO_ONE  = TCW'(1);

  logic [TCW-1:0] to_cnt;

  // Watchdog: zero on entering RUN, one count per RUN cycle; expiry lands on the TIMEOUT_CYC-th RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if (state == RUN) begin
      to_cnt <= to_cnt + TO_ONE;
    end
  end

  assign timeout_hit = (state == RUN) && (to_cnt == TO_LAST);

  // Error flag travels with the result and clears on the result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_err <= 1'b0;
    end else if (cap_ok) begin
      res_err <= 1'b0;
    end else if (cap_to) begin
      res_err <= 1'b1;
    end else if (res_clr) begin
      res_err <= 1'b0;
    end
  end
`else
  // No watchdog: RUN waits for set_valid indefinitely; the comparison is constant false.
  assign timeout_hit = (TIMEOUT_CYC < 0);
  assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_set_job_dispatcher.sv
`timescale 1ns/1ps
// Bench for set_job_dispatcher: behavioural SET engine plus a queue-based reference of the dispatcher.
module tb_set_job_dispatcher;

  localparam int DEPTH       = 4;
  localparam int TAG_W       = 4;
  localparam int TIMEOUT_CYC = 80;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   job_valid;
  logic                   job_ready;
  logic [23:0]            job_central;
  logic [11:0]            job_radius;
  logic [1:0]             job_mode;
  logic [TAG_W-1:0]       job_tag;
  logic                   set_en;
  logic [23:0]            set_central;
  logic [11:0]            set_radius;
  logic [1:0]             set_mode;
  logic                   set_busy;
  logic                   set_valid;
  logic [7:0]             set_candidate;
  logic                   res_valid;
  logic                   res_ready;
  logic [7:0]             res_candidate;
  logic [TAG_W-1:0]       res_tag;
  logic                   res_err;
  logic [$clog2(DEPTH):0] q_count;

  logic       m_busy;
  logic       m_valid;
  logic       f_valid;
  logic [7:0] m_cand;

  assign set_busy      = m_busy;
  assign set_valid     = m_valid | f_valid;
  assign set_candidate = m_cand;

  always #5 clk = ~clk;

  set_job_dispatcher #(
    .DEPTH       (DEPTH),
    .TAG_W       (TAG_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_central   (job_central),
    .job_radius    (job_radius),
    .job_mode      (job_mode),
    .job_tag       (job_tag),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_mode      (set_mode),
    .set_busy      (set_busy),
    .set_valid     (set_valid),
    .set_candidate (set_candidate),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_candidate (res_candidate),
    .res_tag       (res_tag),
    .res_err       (res_err),
    .q_count       (q_count)
  );

  typedef struct packed {
    logic [23:0]      c;
    logic [11:0]      r;
    logic [1:0]       m;
    logic [TAG_W-1:0] t;
  } job_t;

  typedef struct {
    logic [TAG_W-1:0] t;
    logic [7:0]       cand;
    logic             err;
  } res_t;

  job_t mq[$];   // jobs accepted, not yet issued
  res_t fq[$];   // results owed to the host, in issue order

  int n_chk    = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int set_lat  = 4;
  bit set_mute = 1'b0;
  bit last_push;

  // SET behaviour: grid points (0..15)^2 inside any of circles 0..min(mode,2), saturated to 8 bits.
  function automatic logic [7:0] set_ref(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int cnt, nc, cx, cy, rr, dx, dy;
    bit hit;
    cnt = 0;
    nc  = (m > 2'd2) ? 2 : int'(m);
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        hit = 1'b0;
        for (int k = 0; k <= nc; k++) begin
          cx = int'(c[23-8*k -: 4]);
          cy = int'(c[19-8*k -: 4]);
          rr = int'(r[11-4*k -: 4]);
          dx = x - cx;
          dy = y - cy;
          if (dx*dx + dy*dy <= rr*rr) hit = 1'b1;
        end
        if (hit) cnt++;
      end
    end
    return (cnt > 255) ? 8'hFF : 8'(cnt);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: account for handshakes decided by the current inputs, then check the state after the edge.
  task automatic tick();
    job_t j;
    res_t e;
    last_push = job_valid && job_ready;
    if (last_push) begin
      j = {job_central, job_radius, job_mode, job_tag};
      mq.push_back(j);
    end
    if (res_valid && res_ready) begin
      if (fq.size() == 0) begin
        chk("res_unexpected_handshake", res_valid, 1'b0);
      end else begin
        e = fq.pop_front();
        chk("res_tag", res_tag, e.t);
        chk("res_candidate", res_candidate, e.cand);
        chk("res_err", res_err, e.err);
      end
    end
    @(negedge clk);
    if (set_en) begin
      en_cnt++;
      if (mq.size() == 0) begin
        chk("issue_unexpected", set_en, 1'b0);
      end else begin
        j = mq.pop_front();
        chk("set_central", set_central, j.c);
        chk("set_radius", set_radius, j.r);
        chk("set_mode", set_mode, j.m);
        fq.push_back(res_t'{t: j.t, cand: (set_mute ? 8'hFF : set_ref(j.c, j.r, j.m)), err: set_mute});
      end
    end
    chk("q_count", q_count, mq.size());
    chk("job_ready", job_ready, (mq.size() != DEPTH));
    chk("res_valid_unexpected", res_valid && (fq.size() == 0), 1'b0);
  endtask

  task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                          input logic [TAG_W-1:0] t);
    int n;
    job_central = c;
    job_radius  = r;
    job_mode    = m;
    job_tag     = t;
    job_valid   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_push && n < 200);
    chk("push_accepted", last_push, 1'b1);
    job_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 300) begin
      tick();
      n++;
    end
    chk(tag, res_valid, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n;
    res_ready = 1'b1;
    job_valid = 1'b0;
    n = 0;
    while ((mq.size() + fq.size()) != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, mq.size() + fq.size(), 0);
  endtask

  // Behavioural SET engine: busy from issue, one-cycle valid after set_lat cycles; muted jobs never finish.
  initial begin
    int cd;
    logic [7:0] pend;
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_cand  = '0;
    cd      = 0;
    pend    = '0;
    forever begin
      @(negedge clk);
      m_valid = 1'b0;
      if (rst) begin
        m_busy = 1'b0;
        cd     = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          m_valid = 1'b1;
          m_cand  = pend;
          m_busy  = 1'b0;
        end
      end else if (set_en) begin
        m_busy = 1'b1;
        if (!set_mute) begin
          cd   = (set_lat < 1) ? 1 : set_lat;
          pend = set_ref(set_central, set_radius, set_mode);
        end
      end
    end
  end

  initial begin
    logic [7:0]       rc;
    logic [TAG_W-1:0] rt;
    logic [TAG_W-1:0] seq;
    int               n;

    rst = 1'b1; job_valid = 1'b0; job_central = '0; job_radius = '0; job_mode = '0; job_tag = '0;
    res_ready = 1'b0; f_valid = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_q_count", q_count, 0);
    chk("rst_job_ready", job_ready, 1'b1);
    chk("rst_set_en", set_en, 1'b0);
    chk("rst_set_central", set_central, 0);
    chk("rst_set_radius", set_radius, 0);
    chk("rst_set_mode", set_mode, 0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_candidate", res_candidate, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_res_err", res_err, 1'b0);
    rst = 1'b0;

    // Single job: two-cycle issue latency, a single set_en pulse, count 13.
    set_lat = 5; res_ready = 1'b1; en_cnt = 0;
    @(negedge clk);
    job_central = 24'h440000; job_radius = 12'h200; job_mode = 2'd0; job_tag = 4'd3; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    chk("t1_no_en_at_push", set_en, 1'b0);
    tick();
    chk("t1_en_pulse", set_en, 1'b1);
    tick();
    chk("t1_en_one_cycle", set_en, 1'b0);
    wait_res("t1_res_valid");
    chk("t1_cand13", res_candidate, 8'd13);
    chk("t1_tag3", res_tag, 4'd3);
    tick();
    chk("t1_res_released", res_valid, 1'b0);
    chk("t1_single_issue", en_cnt, 1);

    // Fill the queue while job 0 runs; the next job waits for a pop.
    set_lat = 30;
    push_job(24'h123456, 12'h321, 2'd1, 4'd0);
    tick();
    for (int t = 1; t <= 4; t++) begin
      push_job($urandom, $urandom, $urandom, 4'(t));
    end
    chk("t2_full_count", q_count, DEPTH);
    chk("t2_full_ready", job_ready, 1'b0);
    job_central = 24'h777777; job_radius = 12'h444; job_mode = 2'd3; job_tag = 4'd5; job_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_push && n < 200);
    job_valid = 1'b0;
    chk("t2_fifth_held", (n > 20) && last_push, 1'b1);
    drain("t2_drained");

    // Result held for 20 cycles with a job waiting: no issue until the handshake.
    set_lat = 3; res_ready = 1'b0;
    push_job(24'h88AA33, 12'h563, 2'd2, 4'd7);
    push_job(24'h2F0C91, 12'h7A2, 2'd1, 4'd8);
    wait_res("t3_res_valid");
    rc = res_candidate;
    rt = res_tag;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_hold_valid", res_valid, 1'b1);
      chk("t3_hold_cand", res_candidate, rc);
      chk("t3_hold_tag", res_tag, rt);
      chk("t3_no_en_in_hold", set_en, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t3_en_after_hs0", set_en, 1'b0);
    tick();
    chk("t3_en_after_hs1", set_en, 1'b1);
    drain("t3_drained");

    // Push and pop on the same edge with two queued.
    set_lat = 3; res_ready = 1'b0;
    push_job(24'h10F0E1, 12'h345, 2'd0, 4'd1);
    push_job(24'hC3C3C3, 12'h555, 2'd3, 4'd2);
    push_job(24'h0A0B0C, 12'h123, 2'd1, 4'd3);
    wait_res("t4_res_valid");
    chk("t4_q_before", q_count, 2);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    job_central = 24'h5A5A5A; job_radius = 12'h246; job_mode = 2'd2; job_tag = 4'd4; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    chk("t4_pushpop_count", q_count, 2);
    chk("t4_pushpop_issue", set_en, 1'b1);
    drain("t4_drained");

    // Random traffic and host backpressure.
    seq = '0;
    for (int i = 0; i < 400; i++) begin
      job_valid   = $urandom_range(0, 1);
      job_central = $urandom;
      job_radius  = $urandom;
      job_mode    = $urandom;
      job_tag     = seq;
      res_ready   = ($urandom_range(0, 3) != 0);
      set_lat     = $urandom_range(1, 12);
      tick();
      if (last_push) seq = seq + 1'b1;
    end
    drain("t5_drained");

    // Reset in RUN with two queued: everything discarded, a late set_valid is ignored.
    set_lat = 40; res_ready = 1'b1;
    push_job(24'h333333, 12'h111, 2'd0, 4'd9);
    push_job(24'h444444, 12'h222, 2'd1, 4'd10);
    push_job(24'h555555, 12'h333, 2'd2, 4'd11);
    tick();
    chk("t6_q_before_rst", q_count, 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_q", q_count, 0);
    chk("t6_rst_res_valid", res_valid, 1'b0);
    chk("t6_rst_set_en", set_en, 1'b0);
    chk("t6_rst_job_ready", job_ready, 1'b1);
    mq.delete();
    fq.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    f_valid = 1'b1;
    tick();
    f_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_result", res_valid, 1'b0);
    end

    // SET never answers.
    set_mute = 1'b1; res_ready = 1'b0;
    push_job(24'h990000, 12'h300, 2'd0, 4'd5);
    tick();
    chk("t7_issue", set_en, 1'b1);
    n = 0;
    while (!res_valid && n < 150) begin
      tick();
      n++;
    end
`ifdef SJD_TIMEOUT_EN
    chk("t7_timeout_cycles", n, 81);
    chk("t7_timeout_cand", res_candidate, 8'hFF);
    chk("t7_timeout_err", res_err, 1'b1);
    chk("t7_timeout_tag", res_tag, 4'd5);
    res_ready = 1'b1;
    tick();
    chk("t7_err_cleared", res_err, 1'b0);
    chk("t7_valid_cleared", res_valid, 1'b0);
`else
    chk("t7_no_result", res_valid, 1'b0);
    chk("t7_err_zero", res_err, 1'b0);
`endif
    rst = 1'b1;
    mq.delete();
    fq.delete();
    set_mute = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("end_idle_q", q_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/set_job_dispatcher.md
Name: set_job_dispatcher

Overview:
- Front-end for the SET candidate-counting engine. Buffers host jobs (central, radius, mode, tag) in a FIFO and issues them one at a time to SET with a one-cycle enable pulse.
- Captures SET's candidate count on its valid pulse and returns it with the job tag over a valid/ready result interface.
- Sits between the host/testbench driver and SET; owns SET's en/central/radius/mode inputs and consumes its busy/valid/candidate outputs.

Parameters:
- DEPTH, 4: job FIFO entries; power of 2, ≥2.
- TAG_W, 4: job tag width.
- TIMEOUT_CYC, 80: watchdog limit in cycles; used only with SJD_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- job_valid  in  1  host job offered.
- job_ready  out  1  FIFO not full.
- job_central  in  24  three 4-bit (x,y) centre pairs, SET packing.
- job_radius  in  12  three 4-bit radii.
- job_mode  in  2  SET mode 0..3.
- job_tag  in  TAG_W  host tag, returned with the result.
- set_en  out  1  one-cycle start pulse to SET.
- set_central  out  24  to SET, held stable from issue until next issue.
- set_radius  out  12  to SET.
- set_mode  out  2  to SET.
- set_busy  in  1  from SET.
- set_valid  in  1  from SET, one-cycle result pulse.
- set_candidate  in  8  from SET.
- res_valid  out  1  result available.
- res_ready  in  1  host accepts result.
- res_candidate  out  8  captured count.
- res_tag  out  TAG_W  tag of the completed job.
- res_err  out  1  timeout flag; constant 0 without SJD_TIMEOUT_EN.
- q_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1), all registers cleared:
  - FIFO empty, q_count=0, job_ready=1.
  - FSM=IDLE, set_en=0, set_central/radius/mode=0.
  - res_valid=0, res_candidate=0, res_tag=0, res_err=0.
- Reset mid-job discards the in-flight job and all queued jobs. SET shares rst.
- FIFO:
  - Push on job_valid&&job_ready. job_ready = (q_count!=DEPTH), combinational from state.
  - Pop only on the IDLE->ISSUE transition.
  - Simultaneous push and pop: q_count unchanged, both take effect.
  - When full, job_ready=0 and job_valid is ignored.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, RUN, HOLD:
  - IDLE: if q_count!=0 && !set_busy && !res_valid, pop the head into set_* and tag_r, then go to ISSUE.
  - ISSUE: set_en=1 for exactly this one cycle, then go to RUN.
  - RUN: on set_valid=1, capture res_candidate<=set_candidate, res_tag<=tag_r, set res_valid=1, go to HOLD. set_busy is informational only.
  - HOLD: hold res_* stable while res_valid=1. On res_ready=1, clear res_valid at the next edge and go to IDLE.
- Latency:
  - Job pushed at edge N into an empty FIFO with FSM idle: set_en is high in the cycle after edge N+1.
  - The next issue comes at the earliest one cycle after the result handshake.
- Only one job is in flight. Results return in FIFO order.
- set_valid outside RUN is ignored.
- set_* outputs change only on the IDLE->ISSUE edge.

Optional Feature:
- Macro SJD_TIMEOUT_EN.
- When defined:
  - A counter starts at 0 on entering RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYC without set_valid: go to HOLD with res_candidate=8'hFF, res_err=1, res_tag=tag_r.
  - res_err clears on the res_ready handshake.
  - set_valid arriving in the same cycle as the timeout wins: normal result, res_err=0.
- When undefined: no counter is built, res_err is tied 0, and RUN waits indefinitely.

Test Plan:
- Single job, central=24'h440000, radius=12'h200, mode=0, tag=3, res_ready=1: exactly one set_en pulse; res_valid with res_candidate=8'd13, res_tag=3.
- Push 5 jobs back-to-back with DEPTH=4 while the first is in RUN:
  - job_ready drops at q_count=4 and the 5th is held until a pop.
  - Results return with tags 0,1,2,3,4 in order.
- res_ready=0 for 20 cycles after a result:
  - res_valid, res_candidate and res_tag stay stable.
  - No set_en while HOLD.
  - Next set_en only after the handshake.
- Assert rst while in RUN with 2 jobs queued: q_count=0, res_valid=0, set_en=0 immediately. A later set_valid pulse produces no result.
- Simultaneous push and pop at q_count=2: q_count stays 2, FIFO order preserved.
- With SJD_TIMEOUT_EN and TIMEOUT_CYC=80, a SET model that never asserts valid: res_valid rises 80 cycles after entering RUN with res_candidate=8'hFF, res_err=1. Without the macro, res_err stays 0 and no result appears.
